// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS-style core: opcodes, functs,
// ALU selects and the decoded control bundle.
package mips_pkg;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b000100;
    localparam logic [5:0] OP_XORI  = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MOVE  = 6'b001001;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_ctr_t;

    // Main-control request to the ALU control; RTYPE defers to funct.
    typedef enum logic [2:0] {
        AOP_ADD   = 3'b000,
        AOP_SUB   = 3'b001,
        AOP_AND   = 3'b010,
        AOP_OR    = 3'b011,
        AOP_XOR   = 3'b100,
        AOP_SLT   = 3'b101,
        AOP_RTYPE = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic    reg_dst;
        logic    branch;
        logic    bne;
        logic    mem_read;
        logic    mem_write;
        alu_op_t alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    jump;
        logic    jal;
        logic    byte_op;
        logic    move;
        logic    zero_ext;
    } ctrl_t;
endpackage

// File: rtl/alu.sv
// 32-bit ALU; add/sub wrap, no overflow detection.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctr_t    alu_ctr,
    output logic [31:0] y,
    output logic        zero
);
    always_comb begin
        y = '0;
        unique case (alu_ctr)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            default:  y = '0;
        endcase
    end

    assign zero = (y == 32'd0);
endmodule

// File: rtl/alu_control.sv
// Resolves the main-control ALU request and R-type funct into an ALU select.
module alu_control
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output alu_ctr_t   alu_ctr,
    output logic       jr
);
    always_comb begin
        alu_ctr = ALU_ADD;
        jr      = 1'b0;
        unique case (alu_op)
            AOP_SUB: alu_ctr = ALU_SUB;
            AOP_AND: alu_ctr = ALU_AND;
            AOP_OR:  alu_ctr = ALU_OR;
            AOP_XOR: alu_ctr = ALU_XOR;
            AOP_SLT: alu_ctr = ALU_SLT;
            AOP_RTYPE: begin
                jr = (funct == FN_JR);
                unique case (funct[2:0])
                    3'd0: alu_ctr = ALU_ADD;
                    3'd1: alu_ctr = ALU_SUB;
                    3'd2: alu_ctr = ALU_AND;
                    3'd3: alu_ctr = ALU_OR;
                    3'd4: alu_ctr = ALU_XOR;
                    3'd5: alu_ctr = ALU_NOR;
                    3'd6: alu_ctr = ALU_SLT;
                    default: alu_ctr = ALU_SLTU;
                endcase
            end
            default: alu_ctr = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Main decoder: opcode (and funct for R-type write enable) to datapath controls.
module control_unit
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        unique case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = AOP_RTYPE;
                ctrl.move      = (funct == FN_MOVE);
                // jr and unknown functs must not touch the register file
                ctrl.reg_write = (funct[5:3] == 3'b000) || (funct == FN_MOVE);
            end
            OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ANDI: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.zero_ext = 1'b1; ctrl.alu_op = AOP_AND;
            end
            OP_ORI: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.zero_ext = 1'b1; ctrl.alu_op = AOP_OR;
            end
            OP_XORI: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.zero_ext = 1'b1; ctrl.alu_op = AOP_XOR;
            end
            OP_SLTI: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = AOP_SLT;
            end
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.reg_write = 1'b1; end
            OP_BEQ: begin ctrl.branch = 1'b1; ctrl.alu_op = AOP_SUB; end
            OP_BNE: begin ctrl.branch = 1'b1; ctrl.bne = 1'b1; ctrl.alu_op = AOP_SUB; end
            OP_LW: begin
                ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
            end
            OP_LB: begin
                ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1; ctrl.byte_op = 1'b1;
            end
            OP_SW: begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
            OP_SB: begin
                ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.byte_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/register_file.sv
// 32x32 register file, $0 hardwired to zero, two read ports plus a debug read.
module register_file (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);
    logic [31:0] regs [32];

    assign regs[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_reg
        logic [31:0] q;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)                  q <= '0;
            else if (we && wa == 5'(g))  q <= wd;
        end
        assign regs[g] = q;
    end

    assign rd1      = regs[ra1];
    assign rd2      = regs[ra2];
    assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-style CPU: PC, instruction ROM, register file, ALU and
// byte-laned data RAM; every instruction retires on one rising CLK edge.
module mips_cpu
    import mips_pkg::*;
#(
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "instructions.mem"
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    logic [31:0] pc, pc4, pc_next, instr;
    logic [31:0] imem [IMEM_DEPTH];

    // ROM image; words not loaded stay zero, which decodes as a NOP.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    end

    assign instr   = imem[pc[IA+1:2]];
    assign pc4     = pc + 32'd4;
    assign pc_o    = pc;
    assign instr_o = instr;

    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    assign rs  = instr[25:21];
    assign rt  = instr[20:16];
    assign rd  = instr[15:11];
    assign imm = instr[15:0];

    ctrl_t    ctrl;
    alu_ctr_t alu_ctr;
    logic     jr, zero;
    logic [31:0] rd1, rd2, imm_ext, alu_b, alu_y, wd;
    logic [4:0]  wa;

    control_unit u_ctrl (.op(instr[31:26]), .funct(instr[5:0]), .ctrl(ctrl));

    alu_control u_aluc (.alu_op(ctrl.alu_op), .funct(instr[5:0]), .alu_ctr(alu_ctr), .jr(jr));

    assign imm_ext = ctrl.zero_ext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = ctrl.alu_src ? imm_ext : rd2;

    alu u_alu (.a(rd1), .b(alu_b), .alu_ctr(alu_ctr), .y(alu_y), .zero(zero));

    // Data RAM: word index ignores addr[1:0]; lane picks the byte for lb/sb.
    logic [DA-1:0] didx;
    logic [1:0]    lane;
    logic [31:0]   dmem [DMEM_DEPTH];
    logic [31:0]   mem_word;
    logic [7:0]    mem_byte;
    assign didx = alu_y[DA+1:2];
    assign lane = alu_y[1:0];

    for (genvar g = 0; g < DMEM_DEPTH; g++) begin : g_dmem
        logic [31:0] q;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                q <= '0;
            end else if (ctrl.mem_write && didx == DA'(g)) begin
                if (ctrl.byte_op) q[{lane, 3'b000} +: 8] <= rd2[7:0];
                else              q <= rd2;
            end
        end
        assign dmem[g] = q;
    end

    assign mem_word = dmem[didx];
    assign mem_byte = mem_word[{lane, 3'b000} +: 8];

    always_comb begin
        if (ctrl.jal)           wd = pc4;
        else if (ctrl.mem_read) wd = ctrl.byte_op ? {{24{mem_byte[7]}}, mem_byte} : mem_word;
        else if (ctrl.move)     wd = rd1;
        else                    wd = alu_y;
    end

    assign wa = ctrl.jal ? 5'd31 : (ctrl.reg_dst ? rd : rt);

    register_file u_rf (
        .CLK(CLK), .RST_N(RST_N),
        .ra1(rs), .ra2(rt),
        .we(ctrl.reg_write), .wa(wa), .wd(wd),
        .rd1(rd1), .rd2(rd2),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always_comb begin
        pc_next = pc4;
        if (jr)
            pc_next = rd1;
        else if (ctrl.jump)
            pc_next = {pc4[31:28], instr[25:0], 2'b00};
        else if (ctrl.branch && (ctrl.bne ^ zero))
            pc_next = pc4 + {imm_ext[29:0], 2'b00};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pc <= PC_RESET;
        else        pc <= pc_next;
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed program run on mips_cpu: PC/instruction trace and final register
// file contents are scoreboarded against hand-derived values, then resets.
module tb_mips_cpu;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] pc_o, instr_o, dbg_data;
    logic [4:0]  dbg_sel = 5'd0;

    mips_cpu #(.IMEM_FILE("")) dut (
        .CLK(CLK), .RST_N(RST_N), .pc_o(pc_o), .instr_o(instr_o),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [4:0]  sel;
        logic [31:0] val;
        logic [31:0] ins;
    } exp_t;

    exp_t pc_q[$];
    exp_t reg_q[$];
    logic [31:0] prog [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    task automatic push_reg(input int r, input logic [31:0] v);
        exp_t e;
        e.tag = $sformatf("reg%0d", r);
        e.sel = 5'(r);
        e.val = v;
        e.ins = '0;
        reg_q.push_back(e);
    endtask

    // Word indices of the PC after each retired instruction.
    int trace [30] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
                       17, 20, 21, 23, 30, 40, 41, 42, 31, 32, 33, 33, 33};

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) prog[i] = '0;
        prog[0]  = enc_i(6'b000010, 0, 1, 16'd5);          // addi $1,$0,5
        prog[1]  = enc_i(6'b000010, 0, 2, 16'hFFFD);       // addi $2,$0,-3
        prog[2]  = enc_r(1, 2, 3, 6'b000000);              // add  $3,$1,$2
        prog[3]  = enc_r(2, 1, 4, 6'b000001);              // sub  $4,$2,$1
        prog[4]  = enc_r(2, 1, 5, 6'b000110);              // slt  $5,$2,$1
        prog[5]  = enc_r(2, 1, 6, 6'b000111);              // sltu $6,$2,$1
        prog[6]  = enc_i(6'b000100, 0, 10, 16'hF0F0);      // ori  $10,$0,0xF0F0
        prog[7]  = enc_i(6'b000011, 10, 11, 16'h00FF);     // andi $11,$10,0xFF
        prog[8]  = enc_i(6'b000101, 10, 12, 16'hFFFF);     // xori $12,$10,0xFFFF
        prog[9]  = enc_r(10, 0, 13, 6'b001001);            // move $13,$10
        prog[10] = enc_i(6'b000010, 0, 0, 16'd7);          // addi $0,$0,7
        prog[11] = enc_i(6'b100111, 0, 10, 16'd8);         // sw   $10,8($0)
        prog[12] = enc_i(6'b100011, 0, 7, 16'd8);          // lw   $7,8($0)
        prog[13] = enc_i(6'b101000, 0, 10, 16'd13);        // sb   $10,13($0)
        prog[14] = enc_i(6'b100100, 0, 8, 16'd13);         // lb   $8,13($0)
        prog[15] = enc_i(6'b100011, 0, 9, 16'd12);         // lw   $9,12($0)
        prog[16] = enc_i(6'b010000, 1, 2, 16'd5);          // beq  not taken
        prog[17] = enc_i(6'b010000, 3, 3, 16'd2);          // beq  taken -> 20
        prog[18] = enc_i(6'b000010, 0, 20, 16'd1);
        prog[19] = enc_i(6'b000010, 0, 20, 16'd2);
        prog[20] = enc_i(6'b010001, 1, 1, 16'd3);          // bne  not taken
        prog[21] = enc_i(6'b010001, 1, 2, 16'd1);          // bne  taken -> 23
        prog[22] = enc_i(6'b000010, 0, 21, 16'd1);
        prog[23] = enc_j(6'b001000, 30);                   // j 30
        prog[24] = enc_i(6'b000010, 0, 22, 16'd1);
        prog[30] = enc_j(6'b001001, 40);                   // jal 40
        prog[31] = enc_i(6'b000010, 0, 23, 16'd9);         // addi $23,$0,9
        prog[32] = enc_i(6'b100011, 0, 26, 16'd8);         // lw   $26,8($0)
        prog[33] = enc_i(6'b010000, 0, 0, 16'hFFFF);       // beq  self loop
        prog[40] = enc_i(6'b000010, 0, 24, 16'd3);         // addi $24,$0,3
        prog[41] = {6'b111111, 5'd1, 5'd25, 16'h1234};     // undefined opcode
        prog[42] = enc_r(31, 0, 0, 6'b001000);             // jr   $31

        for (int i = 0; i < 256; i++) dut.imem[i] = (i < 64) ? prog[i] : 32'd0;

        for (int k = 0; k < 30; k++) begin
            e.tag = $sformatf("pc[%0d]", k);
            e.sel = '0;
            e.val = 32'(trace[k] * 4);
            e.ins = prog[trace[k]];
            pc_q.push_back(e);
        end

        #1 RST_N = 1'b0;
        #10;
        check("reset_pc", pc_o, 32'd0);
        dbg_sel = 5'd31;
        #1 check("reset_reg31", dbg_data, 32'd0);

        @(negedge CLK);
        RST_N = 1'b1;
        while (pc_q.size() > 0) begin
            e = pc_q.pop_front();
            #1;
            check(e.tag, pc_o, e.val);
            check({e.tag, "_instr"}, instr_o, e.ins);
            @(negedge CLK);
        end

        push_reg(0, 32'd0);          push_reg(1, 32'd5);
        push_reg(2, 32'hFFFF_FFFD);  push_reg(3, 32'd2);
        push_reg(4, 32'hFFFF_FFF8);  push_reg(5, 32'd1);
        push_reg(6, 32'd0);          push_reg(7, 32'h0000_F0F0);
        push_reg(8, 32'hFFFF_FFF0);  push_reg(9, 32'h0000_F000);
        push_reg(10, 32'h0000_F0F0); push_reg(11, 32'h0000_00F0);
        push_reg(12, 32'h0000_0F0F); push_reg(13, 32'h0000_F0F0);
        push_reg(20, 32'd0);         push_reg(21, 32'd0);
        push_reg(22, 32'd0);         push_reg(23, 32'd9);
        push_reg(24, 32'd3);         push_reg(25, 32'd0);
        push_reg(26, 32'h0000_F0F0); push_reg(31, 32'h0000_007C);
        while (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            dbg_sel = e.sel;
            #1 check(e.tag, dbg_data, e.val);
        end

        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 check("midrun_reset_pc", pc_o, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_sel = 5'(i);
            #1 check($sformatf("reset_clr%0d", i), dbg_data, 32'd0);
        end

        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("restart_pc", pc_o, 32'd0);
        check("restart_instr", instr_o, prog[0]);
        @(negedge CLK);
        dbg_sel = 5'd1;
        #1;
        check("restart_pc1", pc_o, 32'd4);
        check("restart_reg1", dbg_data, 32'd5);

        RST_N = 1'b0;
        #1;
        check("abort_pc", pc_o, 32'd0);
        check("abort_reg1", dbg_data, 32'd0);
        dbg_sel = 5'd2;
        #1 check("abort_reg2", dbg_data, 32'd0);

        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rerun_pc", pc_o, 32'd8);
        check("rerun_reg2", dbg_data, 32'hFFFF_FFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
